// File: rtl/led_frame_feeder.sv
// Scan-clock divider and one-deep display-word buffer for the 8-digit scan unit (macro LED_FEEDER_IMMEDIATE_EN: no frame sync).
// Latency: accepted word reaches led_data at the first frame boundary after acceptance; one clk when immediate.
// Backpressure: in_ready falls while a word is pending and rises once the boundary swap empties the buffer.
module led_frame_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_COUNT  = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  scan_clk,
    output logic [DATA_WIDTH-1:0] led_data,
    output logic                  frame_done
);
    localparam logic [23:0] DIV_LAST = 24'(DIV_COUNT - 1);

    logic [23:0] div_cnt;
    logic [2:0]  digit_cnt;
    logic        div_tc;
    logic        scan_rise;
    logic        boundary;
    logic        accept;

    assign div_tc    = (div_cnt == DIV_LAST);
    assign scan_rise = div_tc && !scan_clk;
    // digit_cnt tracks the scan unit, so its 7->0 step marks the end of a full frame
    assign boundary  = scan_rise && (digit_cnt == 3'd7);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            scan_clk   <= 1'b0;
            digit_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (div_tc) begin
                div_cnt  <= '0;
                scan_clk <= !scan_clk;
            end else begin
                div_cnt <= div_cnt + 24'd1;
            end
            if (scan_rise) begin
                digit_cnt <= digit_cnt + 3'd1;
            end
        end
    end

`ifdef LED_FEEDER_IMMEDIATE_EN
    assign in_ready = rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_data <= '0;
        end else if (accept) begin
            led_data <= in_data;
        end
    end
`else
    logic                  pending_full;
    logic [DATA_WIDTH-1:0] pending_reg;

    assign in_ready = rst_n && !pending_full;

    // accept needs an empty buffer and the swap needs a full one, so they never collide
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_full <= 1'b0;
            pending_reg  <= '0;
            led_data     <= '0;
        end else begin
            if (boundary && pending_full) begin
                led_data     <= pending_reg;
                pending_full <= 1'b0;
            end
            if (accept) begin
                pending_reg  <= in_data;
                pending_full <= 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_led_frame_feeder.sv
// Directed bench for led_frame_feeder with DIV_COUNT=2 (frame = 32 clks, first boundary 30 clks after reset release).
module tb_led_frame_feeder;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          scan_clk;
    logic [DW-1:0] led_data;
    logic          frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    led_frame_feeder #(.DATA_WIDTH(DW), .DIV_COUNT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .scan_clk  (scan_clk),
        .led_data  (led_data),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic          vld;
        logic [DW-1:0] dat;
        int            ncyc;
        logic          e_scan;
        logic          e_rdy;
        logic          e_done;
        logic [DW-1:0] e_led;
    } vec_t;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input int idx, input vec_t v);
        check($sformatf("v%0d scan_clk", idx), {31'd0, scan_clk}, {31'd0, v.e_scan});
        check($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, {31'd0, v.e_rdy});
        check($sformatf("v%0d frame_done", idx), {31'd0, frame_done}, {31'd0, v.e_done});
        check($sformatf("v%0d led_data", idx), led_data, v.e_led);
    endtask

`ifdef LED_FEEDER_IMMEDIATE_EN
    vec_t vecs[4];
    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        #1;
        vecs[0] = '{1'b0, 1'b0, 32'h0,        3, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h0,        1, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 32'h55AA55AA, 1, 1'b1, 1'b1, 1'b0, 32'h55AA55AA};
        vecs[3] = '{1'b1, 1'b1, 32'h12345678, 1, 1'b1, 1'b1, 1'b0, 32'h12345678};
        for (int i = 0; i < 4; i++) begin
            rst_n = vecs[i].rst_n; in_valid = vecs[i].vld; in_data = vecs[i].dat;
            step(vecs[i].ncyc);
            check_outputs(i, vecs[i]);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
`else
    vec_t vecs[18];
    initial begin
        int first_edge;
        int second_edge;
        int toggles;
        logic prev_scan;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        #1;
        // edge numbers in comments count posedges since reset release (e1 = first)
        vecs[0]  = '{1'b0, 1'b0, 32'h0,         3, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,         1, 1'b0, 1'b1, 1'b0, 32'h0};        // e1
        vecs[2]  = '{1'b1, 1'b0, 32'h0,         1, 1'b1, 1'b1, 1'b0, 32'h0};        // e2 first rise
        vecs[3]  = '{1'b1, 1'b0, 32'h0,         2, 1'b0, 1'b1, 1'b0, 32'h0};        // e4
        vecs[4]  = '{1'b1, 1'b1, 32'h12345678,  1, 1'b0, 1'b0, 1'b0, 32'h0};        // e5 accept
        vecs[5]  = '{1'b1, 1'b1, 32'hDEADBEEF, 24, 1'b0, 1'b0, 1'b0, 32'h0};        // e29 held off
        vecs[6]  = '{1'b1, 1'b1, 32'hDEADBEEF,  1, 1'b1, 1'b1, 1'b1, 32'h12345678}; // e30 boundary
        vecs[7]  = '{1'b1, 1'b1, 32'hDEADBEEF,  1, 1'b1, 1'b0, 1'b0, 32'h12345678}; // e31 accept
        vecs[8]  = '{1'b1, 1'b0, 32'h0,        30, 1'b0, 1'b0, 1'b0, 32'h12345678}; // e61
        vecs[9]  = '{1'b1, 1'b0, 32'h0,         1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF}; // e62 boundary
        vecs[10] = '{1'b1, 1'b0, 32'h0,        31, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF}; // e93
        vecs[11] = '{1'b1, 1'b1, 32'hCAFEF00D,  1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF}; // e94 accept on boundary
        vecs[12] = '{1'b1, 1'b0, 32'h0,         1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF}; // e95
        vecs[13] = '{1'b1, 1'b0, 32'h0,        31, 1'b1, 1'b1, 1'b1, 32'hCAFEF00D}; // e126 boundary
        vecs[14] = '{1'b1, 1'b1, 32'h0BADF00D,  1, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D}; // e127 accept
        vecs[15] = '{1'b0, 1'b0, 32'h0,         1, 1'b0, 1'b0, 1'b0, 32'h0};        // reset pulse
        vecs[16] = '{1'b1, 1'b0, 32'h0,         1, 1'b0, 1'b1, 1'b0, 32'h0};        // new e1
        vecs[17] = '{1'b1, 1'b0, 32'h0,        40, 1'b0, 1'b1, 1'b0, 32'h0};        // new e41, past e30
        for (int i = 0; i < 18; i++) begin
            rst_n = vecs[i].rst_n; in_valid = vecs[i].vld; in_data = vecs[i].dat;
            step(vecs[i].ncyc);
            check_outputs(i, vecs[i]);
        end

        // scan_clk toggles every 2 clks: 4 toggles in 8 edges
        toggles = 0;
        prev_scan = scan_clk;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (scan_clk !== prev_scan) toggles++;
            prev_scan = scan_clk;
        end
        check("scan_clk toggles in 8 clks", 32'(toggles), 32'd4);

        // frame_done spacing between consecutive pulses is 32 clks
        first_edge = -1;
        second_edge = -1;
        for (int i = 1; i <= 80; i++) begin
            step(1);
            if (frame_done === 1'b1) begin
                if (first_edge < 0) first_edge = i;
                else if (second_edge < 0) second_edge = i;
            end
        end
        check("frame_done seen twice", {31'd0, (first_edge >= 0 && second_edge >= 0)}, 32'd1);
        check("frame_done period", 32'(second_edge - first_edge), 32'd32);
        check("led_data still blank", led_data, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
`endif
endmodule

// File: doc/led_frame_feeder.md
Name: led_frame_feeder

Overview:
Upstream feeder for the 8-digit seven-segment scan unit. Divides the system clock into the scan clock that steps the scan unit's digit counter. Supplies the DATA_WIDTH-bit display word through a one-deep valid/ready buffer. New words reach the display only at a frame boundary, so a scan frame never shows a mix of old and new digits.

Parameters:
DATA_WIDTH, 32, width of the display word (8 hex digits).
DIV_COUNT, 50000, system clocks per scan_clk half-period; legal range 1..2^24-1.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst_n  input  1  synchronous, active-low reset.
in_data  input  DATA_WIDTH  display word offered by the producer.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  feeder can accept a word this cycle.
scan_clk  output  1  scan clock driving the scan unit's clk_src.
led_data  output  DATA_WIDTH  word currently displayed; drives the scan unit's led_data.
frame_done  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (rst_n low at a clk edge) sets: div_cnt=0, scan_clk=0, digit_cnt=0, led_data=0, pending_full=0, frame_done=0. in_ready is forced 0 while rst_n is low.
- Reset applied mid-operation discards any pending word and blanks led_data to 0.
- Divider: div_cnt counts 0..DIV_COUNT-1. At terminal count, div_cnt wraps to 0 and scan_clk toggles. scan_clk period = 2*DIV_COUNT clks. With DIV_COUNT=1, scan_clk toggles every cycle.
- digit_cnt (3 bits) increments on the clk edge where scan_clk goes 0->1. It wraps 7->0 and mirrors the scan unit's internal count. Both counters start at 0 out of reset.
- Frame boundary: the clk edge where scan_clk goes 0->1 and digit_cnt goes 7->0. One frame = 16*DIV_COUNT clks.
- Handshake:
  - in_ready = !pending_full (registered source, no combinational path from in_valid).
  - Accept when in_valid && in_ready: pending_reg <= in_data, pending_full <= 1.
  - The producer must hold in_data stable while in_valid=1 && in_ready=0.
- Swap at frame boundary:
  - If pending_full=1: led_data <= pending_reg, pending_full <= 0.
  - If pending_full=0: led_data holds.
- frame_done = 1 for exactly the frame-boundary cycle, every frame, whether or not a swap occurs.
- No bypass: a word accepted on the boundary cycle itself (pending empty before that edge) is stored in pending and is displayed at the next boundary.
- Because in_ready=0 while pending is full, accept and swap never target the same full buffer.
- led_data changes only at a frame boundary or at reset.
- Latency: a word accepted at cycle t appears on led_data at the first frame boundary strictly after t.

Optional Feature:
Macro LED_FEEDER_IMMEDIATE_EN.
- Defined:
  - The frame sync is removed; an accepted word loads led_data on the next edge.
  - in_ready = 1 whenever rst_n is high.
  - pending_reg is not used.
  - frame_done and scan_clk are unchanged.
- Undefined: frame-synchronous behaviour exactly as described above.

Test Plan:
1. Hold rst_n=0 for 3 clks -> scan_clk=0, led_data=0, in_ready=0, frame_done=0. Release -> in_ready=1 on the next cycle.
2. DIV_COUNT=2, no input -> scan_clk toggles every 2 clks (period 4). frame_done pulses once every 32 clks; first pulse on the 8th scan_clk rise.
3. DIV_COUNT=2: at clk 5 after reset, drive in_valid=1 with in_data=0x12345678 -> in_ready=0 the following cycle. led_data stays 0x00000000 until the first boundary, then becomes 0x12345678 on the same edge frame_done=1. in_ready returns to 1 on the next cycle.
4. Back-pressure: offer 0xDEADBEEF with in_valid held high while pending is full -> no accept until in_ready=1. Word then accepted once; displayed one frame after 0x12345678. No word is duplicated or lost.
5. With pending empty, assert in_valid with 0xCAFEF00D exactly on the boundary cycle -> led_data unchanged at that boundary; becomes 0xCAFEF00D at the next boundary (16*DIV_COUNT clks later).
6. With pending full holding 0x0BADF00D, pulse rst_n=0 for 1 clk -> led_data=0, in_ready=1 after release. 0x0BADF00D never appears on led_data.
   With LED_FEEDER_IMMEDIATE_EN defined: accept 0x55AA55AA -> led_data=0x55AA55AA one clk later, in_ready stays 1.
